// File: rtl/jedro_1_dbus_arbiter.sv
// jedro_1_dbus_arbiter: two-master round-robin arbiter for the jedro-1 data bus with response timeout
module jedro_1_dbus_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  m0_stb_i,
  input  logic [3:0]            m0_we_i,
  input  logic [DATA_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_stb_i,
  input  logic [3:0]            m1_we_i,
  input  logic [DATA_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_stb_o,
  output logic [3:0]            s_we_o,
  output logic [DATA_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_wdata_o,
  input  logic [DATA_WIDTH-1:0] s_rdata_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  logic [0:0] state;
  logic [7:0] cnt;
  logic gnt, last_grant, sel, start, timeout, done, fail;
  logic [1:0] valid, stb;
  logic [1:0][3:0] we_in, buf_we;
  logic [1:0][DATA_WIDTH-1:0] addr_in, wdata_in, buf_addr, buf_wdata;
  assign stb      = {m1_stb_i, m0_stb_i};
  assign we_in    = {m1_we_i, m0_we_i};
  assign addr_in  = {m1_addr_i, m0_addr_i};
  assign wdata_in = {m1_wdata_i, m0_wdata_i};
  always_comb begin
    sel     = (valid == 2'b11) ? ~last_grant : valid[1];
    start   = (state == IDLE) && |valid;
    // the strobe cycle itself is not counted as a wait cycle
    timeout = !s_stb_o && (cnt == CNT_LAST);
    done    = (state == WAIT) && (s_ack_i || s_err_i || timeout);
    fail    = s_err_i || !s_ack_i;
  end
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      valid      <= '0;
      buf_we     <= '0;
      buf_addr   <= '0;
      buf_wdata  <= '0;
      s_stb_o    <= 1'b0;
      s_we_o     <= '0;
      s_addr_o   <= '0;
      s_wdata_o  <= '0;
      m0_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m0_rdata_o <= '0;
      m1_ack_o   <= 1'b0;
      m1_err_o   <= 1'b0;
      m1_rdata_o <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (stb[i] && !valid[i]) begin
          valid[i]     <= 1'b1;
          buf_we[i]    <= we_in[i];
          buf_addr[i]  <= addr_in[i];
          buf_wdata[i] <= wdata_in[i];
        end else if (done && gnt == 1'(i)) begin
          valid[i] <= 1'b0;
        end
      end
      s_stb_o <= start;
      s_we_o  <= start ? buf_we[sel] : 4'b0;
      if (start) begin
        state     <= WAIT;
        gnt       <= sel;
        cnt       <= '0;
        s_addr_o  <= buf_addr[sel];
        s_wdata_o <= buf_wdata[sel];
      end
      if (state == WAIT && !done && !s_stb_o) cnt <= cnt + 8'd1;
      if (done) begin
        state      <= IDLE;
        last_grant <= gnt;
      end
      m0_ack_o <= done && !fail && !gnt;
      m0_err_o <= done && fail && !gnt;
      m1_ack_o <= done && !fail && gnt;
      m1_err_o <= done && fail && gnt;
      if (done && !fail && !gnt) m0_rdata_o <= s_rdata_i;
      if (done && !fail && gnt) m1_rdata_o <= s_rdata_i;
    end
  end
endmodule

// File: tb/tb_jedro_1_dbus_arbiter.sv
// tb_jedro_1_dbus_arbiter: directed and randomized checks of the data bus arbiter against a transaction-level model
module tb_jedro_1_dbus_arbiter;
  localparam int DW = 32;
  localparam int TO = 15;
  logic clk_i = 1'b0;
  logic rstn_i;
  logic m0_stb_i, m1_stb_i, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [3:0] m0_we_i, m1_we_i, s_we_o;
  logic [DW-1:0] m0_addr_i, m0_wdata_i, m0_rdata_o, m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic s_stb_o, s_ack_i, s_err_i;
  logic [DW-1:0] s_addr_o, s_wdata_o, s_rdata_i;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rd_exp [2];
  bit last;
  logic [31:0] a_exp [2];
  logic [31:0] d_exp [2];
  logic [3:0] w_exp [2];
  logic [31:0] rdv;
  logic [1:0] pend, ea, ee, extra;
  bit cur, oth, ok, busy;
  int cyc, exp_stb, resp_at, done_at, kind;

  jedro_1_dbus_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input bit k, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
    if (k) begin
      m1_stb_i = 1'b1; m1_we_i = we; m1_addr_i = a; m1_wdata_i = wd;
    end else begin
      m0_stb_i = 1'b1; m0_we_i = we; m0_addr_i = a; m0_wdata_i = wd;
    end
  endtask

  task automatic idle_in();
    m0_stb_i = 1'b0;
    m1_stb_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_stb_o, s_we_o}, 64'd0);
    chk({tag, "_saddr"}, s_addr_o, 64'd0);
    chk({tag, "_swdata"}, s_wdata_o, 64'd0);
    chk({tag, "_m0_rdata"}, m0_rdata_o, 64'd0);
    chk({tag, "_m1_rdata"}, m1_rdata_o, 64'd0);
  endtask

  task automatic do_reset();
    idle_in();
    s_ack_i = 1'b0; s_err_i = 1'b0;
    rstn_i = 1'b0;
    tick();
    tick();
    rstn_i = 1'b1;
    rd_exp[0] = '0; rd_exp[1] = '0;
    last = 1'b1;
    chk_zero("reset");
  endtask

  // called in the cycle the strobe is due; returns in the completion cycle
  task automatic serve(input bit k, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input logic [1:0] resp);
    bit good;
    good = (resp == 2'b01);
    chk("serve_stb", s_stb_o, 64'd1);
    chk("serve_addr", s_addr_o, a);
    chk("serve_we", s_we_o, we);
    chk("serve_wdata", s_wdata_o, wd);
    tick();
    s_ack_i = resp[0]; s_err_i = resp[1]; s_rdata_i = rd;
    chk("wait_stb", s_stb_o, 64'd0);
    chk("wait_we", s_we_o, 64'd0);
    tick();
    s_ack_i = 1'b0; s_err_i = 1'b0;
    if (good) rd_exp[k] = rd;
    last = k;
    chk("m0_ack", m0_ack_o, good && !k);
    chk("m0_err", m0_err_o, !good && !k);
    chk("m1_ack", m1_ack_o, good && k);
    chk("m1_err", m1_err_o, !good && k);
    chk("m0_rdata", m0_rdata_o, rd_exp[0]);
    chk("m1_rdata", m1_rdata_o, rd_exp[1]);
    chk("done_stb", s_stb_o, 64'd0);
  endtask

  initial begin
    m0_we_i = '0; m0_addr_i = '0; m0_wdata_i = '0;
    m1_we_i = '0; m1_addr_i = '0; m1_wdata_i = '0;
    s_rdata_i = '0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_stb", s_stb_o, 64'd0);
    end
    // single read, ack visible four cycles after the request
    req(0, 4'b0000, 32'h100, 32'h0);
    tick(); idle_in(); tick();
    serve(0, 4'b0000, 32'h100, 32'h0, 32'hDEADBEEF, 2'b01);
    chk("single_m1_quiet", {m1_ack_o, m1_err_o, m1_rdata_o}, 64'd0);
    // simultaneous pair after reset: m0 wins the first tie
    do_reset();
    req(0, 4'b0011, 32'h04, 32'h0000ABCD); req(1, 4'b0000, 32'h08, 32'h0);
    tick(); idle_in(); tick();
    serve(0, 4'b0011, 32'h04, 32'h0000ABCD, 32'h11111111, 2'b01);
    tick();
    serve(1, 4'b0000, 32'h08, 32'h0, 32'h22222222, 2'b01);
    // m0 served last, so the repeated pair goes to m1 first
    req(0, 4'b1111, 32'h10, 32'h55);
    tick(); idle_in(); tick();
    serve(0, 4'b1111, 32'h10, 32'h55, 32'h33333333, 2'b01);
    req(0, 4'b0011, 32'h04, 32'h0000ABCD); req(1, 4'b0000, 32'h08, 32'h0);
    tick(); idle_in(); tick();
    serve(1, 4'b0000, 32'h08, 32'h0, 32'h44444444, 2'b01);
    tick();
    serve(0, 4'b0011, 32'h04, 32'h0000ABCD, 32'h66666666, 2'b01);
    // timeout: silent slave gives m1_err_o TIMEOUT+1 cycles after the strobe
    req(1, 4'b0000, 32'h40, 32'h0);
    tick(); idle_in(); tick();
    chk("to_stb", s_stb_o, 64'd1);
    chk("to_addr", s_addr_o, 64'h40);
    for (int i = 1; i <= TO + 1; i++) begin
      tick();
      s_rdata_i = 32'hA5A5A5A5;
      chk("to_m1_ack", m1_ack_o, 64'd0);
      chk("to_m1_err", m1_err_o, i == TO + 1);
    end
    chk("to_m1_rdata", m1_rdata_o, rd_exp[1]);
    tick(); tick();
    s_ack_i = 1'b1; s_rdata_i = 32'hFFFF0000;
    tick();
    s_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_stb_o}, 64'd0);
      chk("late_m1_rdata", m1_rdata_o, rd_exp[1]);
      tick();
    end
    // ack and err together resolve to an error
    req(0, 4'b0000, 32'h80, 32'h0);
    tick(); idle_in(); tick();
    serve(0, 4'b0000, 32'h80, 32'h0, 32'h00000BAD, 2'b11);
    // second stb while the buffer is valid is dropped
    req(0, 4'b0000, 32'h300, 32'h0);
    tick();
    req(0, 4'b1111, 32'h200, 32'h99);
    tick(); idle_in();
    serve(0, 4'b0000, 32'h300, 32'h0, 32'h77777777, 2'b01);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drop_no_stb", s_stb_o, 64'd0);
    end
    // reset in the middle of WAIT
    req(0, 4'b0000, 32'h500, 32'h0);
    tick(); idle_in(); tick();
    chk("mid_stb", s_stb_o, 64'd1);
    tick();
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    rd_exp[0] = '0; rd_exp[1] = '0;
    last = 1'b1;
    chk_zero("mid_reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_quiet", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_stb_o}, 64'd0);
    end
    req(1, 4'b0000, 32'h600, 32'h0);
    tick(); idle_in(); tick();
    serve(1, 4'b0000, 32'h600, 32'h0, 32'h00001234, 2'b01);
    // randomized traffic against a transaction schedule model
    do_reset();
    for (int it = 0; it < 60; it++) begin
      pend = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        a_exp[k] = $urandom; d_exp[k] = $urandom; w_exp[k] = 4'($urandom);
        if (pend[k]) req(k[0], w_exp[k], a_exp[k], d_exp[k]);
      end
      cyc = 0; exp_stb = 2; resp_at = -1; done_at = -1; busy = 0; kind = 0; extra = '0;
      while (pend != 0 && cyc < 200) begin
        tick();
        cyc++;
        idle_in();
        s_ack_i = (cyc == resp_at) && kind != 0;
        s_err_i = (cyc == resp_at) && kind != 2;
        s_rdata_i = $urandom;
        if (cyc == resp_at) rdv = s_rdata_i;
        ea = '0; ee = '0;
        if (cyc == done_at) begin
          if (ok) begin
            ea[cur] = 1'b1;
            rd_exp[cur] = rdv;
          end else begin
            ee[cur] = 1'b1;
          end
          pend[cur] = 1'b0;
          last = cur;
          busy = 0;
          if (pend != 0) exp_stb = cyc + 1;
        end
        chk("rnd_stb", s_stb_o, cyc == exp_stb);
        if (cyc == exp_stb) begin
          cur = (pend == 2'b11) ? ~last : pend[1];
          chk("rnd_addr", s_addr_o, a_exp[cur]);
          chk("rnd_we", s_we_o, w_exp[cur]);
          chk("rnd_wdata", s_wdata_o, d_exp[cur]);
          busy = 1;
          extra = 2'($urandom);
          if ($urandom_range(0, 5) == 0) begin
            resp_at = -1; ok = 0; done_at = cyc + TO + 1;
          end else begin
            resp_at = cyc + $urandom_range(1, 4);
            kind = $urandom_range(0, 3);
            if (kind > 2) kind = 2;
            ok = (kind == 2);
            done_at = resp_at + 1;
          end
        end
        if (busy && cyc == exp_stb + 1) begin
          oth = ~cur;
          if (extra[0] && !pend[oth]) begin
            a_exp[oth] = $urandom; d_exp[oth] = $urandom; w_exp[oth] = 4'($urandom);
            pend[oth] = 1'b1;
            req(oth, w_exp[oth], a_exp[oth], d_exp[oth]);
          end
          if (extra[1]) req(cur, 4'($urandom), $urandom, $urandom);
        end
        if (!s_stb_o) chk("rnd_we_gate", s_we_o, 64'd0);
        chk("rnd_m0_ack", m0_ack_o, ea[0]);
        chk("rnd_m0_err", m0_err_o, ee[0]);
        chk("rnd_m1_ack", m1_ack_o, ea[1]);
        chk("rnd_m1_err", m1_err_o, ee[1]);
        chk("rnd_m0_rdata", m0_rdata_o, rd_exp[0]);
        chk("rnd_m1_rdata", m1_rdata_o, rd_exp[1]);
      end
      idle_in();
      chk("rnd_all_served", pend, 64'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jedro_1_dbus_arbiter.md
# jedro_1_dbus_arbiter

Two-master, one-slave arbiter for the jedro-1 data bus. It lets the core's load-store unit (master 0) and a secondary data master, such as a debug or DMA port (master 1), share a single data RAM port that uses the stb/we/ack/err handshake. Each master has a one-entry request buffer. Masters are served round-robin, one transaction at a time. Every transaction is bounded by a response timeout that turns a silent slave into a bus error.

## Interface
- `DATA_WIDTH`, default 32: address and data width.
- `TIMEOUT`, default 15: number of WAIT cycles without a slave response before the arbiter forces an error. Legal range 1..255.
- `clk_i` input 1: clock; all logic is on the rising edge.
- `rstn_i` input 1: reset, synchronous and active-low.
- `m0_stb_i` / `m1_stb_i` input 1: single-cycle request pulse from master N.
- `m0_we_i` / `m1_we_i` input 4: byte write enables; all zero means a read.
- `m0_addr_i` / `m1_addr_i` input DATA_WIDTH: address.
- `m0_wdata_i` / `m1_wdata_i` input DATA_WIDTH: write data, already lane-aligned.
- `m0_rdata_o` / `m1_rdata_o` output DATA_WIDTH: read data returned to master N.
- `m0_ack_o` / `m1_ack_o` output 1: one-cycle pulse, transaction completed successfully.
- `m0_err_o` / `m1_err_o` output 1: one-cycle pulse, transaction ended in a bus error or timeout.
- `s_stb_o` output 1: one-cycle strobe to the slave.
- `s_we_o` output 4: byte write enables to the slave.
- `s_addr_o` output DATA_WIDTH: address to the slave.
- `s_wdata_o` output DATA_WIDTH: write data to the slave.
- `s_rdata_i` input DATA_WIDTH: read data from the slave.
- `s_ack_i` input 1: slave acknowledge.
- `s_err_i` input 1: slave error.

## Operation
- **Request buffers.** Each master has one buffer: valid bit, we, addr, wdata.
  - `mN_stb_i=1` while buffer N is invalid captures {we, addr, wdata} and sets valid.
  - `mN_stb_i` while buffer N is valid is a protocol violation. The request is silently dropped and the buffer keeps its contents.
- **FSM states.**
  - IDLE:
    - If no buffer is valid, stay in IDLE.
    - If exactly one buffer is valid, grant it.
    - If both are valid, grant the master not in `last_grant`.
    - On a grant: register `s_stb_o=1`, drive `s_we_o`/`s_addr_o`/`s_wdata_o` from the granted buffer, clear the timeout counter, go to WAIT.
  - WAIT:
    - `s_stb_o=0`; `s_addr_o` and `s_wdata_o` hold their values.
    - `s_err_i=1`: end the transaction with an error.
    - Otherwise `s_ack_i=1`: end the transaction successfully.
    - Otherwise, if the counter equals TIMEOUT-1: end the transaction with an error (timeout).
    - Otherwise increment the counter.
    - On ending: clear the granted buffer's valid bit, set `last_grant`, go to IDLE.
- **Completion.**
  - Success: `mN_ack_o=1` for one cycle and `mN_rdata_o <= s_rdata_i`. The value is captured for writes too.
  - Error: `mN_err_o=1` for one cycle; `mN_rdata_o` is unchanged.
  - `ack_o` and `err_o` are never both high.
  - Only the granted master's outputs change.
- **Stray responses.** `s_ack_i` or `s_err_i` seen in IDLE is ignored, including a late response after a timeout.
- **`s_we_o` gating.** `s_we_o` is forced to 0 whenever `s_stb_o=0`.
- **Rdata hold.** `mN_rdata_o` holds its value until the next successful completion for master N.
- **Reset** (at any time, including mid-transaction):
  - FSM goes to IDLE, both buffers become invalid, counter clears.
  - `last_grant` is set to 1, so master 0 wins the first tie.
  - All outputs go to 0.
  - No ack or err is issued for the aborted transaction.

## Timing
- **Outputs are registered.** There is no combinational path from any input to any output.
- **Unloaded read, single-cycle slave:**
  - cycle 0: `m0_stb_i`.
  - cycle 1: buffer valid; the arbiter is in IDLE.
  - cycle 2: `s_stb_o`.
  - cycle 3: `s_ack_i`.
  - cycle 4: `m0_ack_o` with rdata.
  - Latency from stb to ack is 4 cycles.
- **Throughput.**
  - The arbiter returns to IDLE in the cycle after the response and issues the next `s_stb_o` one cycle later.
  - Minimum spacing between slave strobes is 3 cycles.
- **Timeout.** With no response, `mN_err_o` is asserted TIMEOUT+1 cycles after `s_stb_o`.
- **New requests.**
  - A master may issue its next stb in the same cycle as its `ack_o`/`err_o`, or later; it is captured because the buffer cleared one cycle earlier.
  - A stb issued in the cycle the slave responds is dropped.
- **Capture during WAIT.** A stb from the non-granted master during WAIT is captured and served at the next IDLE.

## Test plan
- **Reset values:** hold `rstn_i=0` for 2 cycles → every output is 0 and `s_stb_o` stays 0 for 5 idle cycles.
- **Single read:** m0 read of addr 0x100, slave acks 1 cycle after `s_stb_o` with 0xDEADBEEF → `m0_ack_o` in cycle 4 and `m0_rdata_o=0xDEADBEEF`; m1 outputs stay 0.
- **Simultaneous requests:**
  - m0 write (we=4'b0011, addr 0x04, wdata 0x0000ABCD) and m1 read (addr 0x08) in the same cycle → m0 is served first, `s_we_o=4'b0011`; m1 is served on the next `s_stb_o`, 3 cycles later.
  - Repeat the same pair → m1 is served first.
- **Timeout:**
  - With TIMEOUT=15, the slave never responds → `m1_err_o` is asserted 16 cycles after `s_stb_o`, and `m1_rdata_o` is unchanged.
  - A late `s_ack_i` 2 cycles after that → no ack on either master.
- **Ack and err together:** `s_ack_i=s_err_i=1` in the same cycle → `err_o=1`, `ack_o=0`, rdata unchanged.
- **Violation and mid-transaction reset:**
  - A second `m0_stb_i` (addr 0x200) while m0's buffer is valid → only the first address appears on `s_addr_o`.
  - Assert `rstn_i=0` during WAIT → no ack or err is issued, and the next request after reset issues normally.
